// File: rtl/fir_tdm_pkg.sv
// Shared state encoding, standard-build widths and result rounding for the TDM FIR scheduler.
// Build option FIR_TDM_SAT_EN: clamp results to the DW range instead of two's-complement wrap.
package fir_tdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int NCH_DEF  = 4;
    localparam int TAPS_DEF = 8;
    localparam int DW_DEF   = 16;
    localparam int CW_DEF   = 16;

    localparam int ACCW = DW_DEF + CW_DEF + $clog2(TAPS_DEF);
    localparam int PTRW = $clog2(TAPS_DEF);
    localparam int CHW  = $clog2(NCH_DEF);

    // Round half up from Q(CW-1) back to integer; caller keeps the low dw bits.
    function automatic logic signed [63:0] round_narrow(input logic signed [63:0] acc,
                                                        input int dw, input int cw);
        logic signed [63:0] r;
        r = (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
`ifdef FIR_TDM_SAT_EN
        if (r > ((64'sd1 <<< (dw - 1)) - 64'sd1))
            r = (64'sd1 <<< (dw - 1)) - 64'sd1;
        else if (r < -(64'sd1 <<< (dw - 1)))
            r = -(64'sd1 <<< (dw - 1));
`else
        if (dw < 1)
            r = '0;
`endif
        return r;
    endfunction

endpackage

// File: rtl/fir_tdm_sched_rr_arb.sv
// NCH-way round-robin arbiter; search starts one past the last granted channel.
module fir_tdm_rr_arb #(
    parameter int NCH = 4,
    parameter int CHW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] grant,
    output logic [CHW-1:0] grant_ch
);

    logic [CHW-1:0] ptr;
    logic [CHW:0]   idx;

    // Walk farthest-to-nearest so the channel closest to ptr wins.
    always_comb begin
        grant    = '0;
        grant_ch = '0;
        idx      = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + (CHW + 1)'(i);
            if (idx >= (CHW + 1)'(NCH))
                idx = idx - (CHW + 1)'(NCH);
            if (en && req[idx[CHW-1:0]]) begin
                grant                = '0;
                grant[idx[CHW-1:0]]  = 1'b1;
                grant_ch             = idx[CHW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (|grant)
            ptr <= (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
    end

endmodule

// File: rtl/fir_tdm_sched.sv
// Round-robin TDM scheduler sequencing one shared signed FIR MAC over NCH channel delay lines.
// Build option FIR_TDM_SAT_EN: saturate results to the DW range instead of wrapping.
//
// state | meaning
// IDLE  | accept a coefficient write, else grant one channel sample
// MAC   | TAPS multiply-accumulate cycles for the granted channel
// OUT   | hold the tagged result until downstream accepts it
module fir_tdm_sched
    import fir_tdm_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int TAPS = 8,
    parameter int DW   = 16,
    parameter int CW   = 16
) (
    input  logic                     system1000,
    input  logic                     system1000_rstn,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*DW-1:0]        in_data,
    output logic [NCH-1:0]           in_ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_data,
    output logic                     coef_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [DW-1:0]            out_data
);

    // Package widths describe the standard build; other parameter sets derive their own.
    localparam bit STD   = (NCH == NCH_DEF) && (TAPS == TAPS_DEF) && (DW == DW_DEF) && (CW == CW_DEF);
    localparam int CH_W  = STD ? CHW  : $clog2(NCH);
    localparam int PTR_W = STD ? PTRW : $clog2(TAPS);
    localparam int ACC_W = STD ? ACCW : DW + CW + $clog2(TAPS);

    state_t                   state;
    logic signed [DW-1:0]     hist [NCH][TAPS];
    logic signed [CW-1:0]     coef [TAPS];
    logic [PTR_W-1:0]         wp   [NCH];
    logic [CH_W-1:0]          cur_ch;
    logic [PTR_W-1:0]         mac_cnt;
    logic signed [ACC_W-1:0]  acc;

    logic                     arb_en;
    logic [NCH-1:0]           grant;
    logic [CH_W-1:0]          grant_ch;
    logic [DW-1:0]            sample;
    logic [PTR_W-1:0]         tap_k;
    logic [PTR_W-1:0]         rd_idx;
    logic signed [DW+CW-1:0]  prod;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [63:0]       acc_ext;

    assign arb_en     = (state == IDLE) && !coef_we && system1000_rstn;
    assign in_ready   = grant;
    assign coef_ready = (state == IDLE);
    assign out_valid  = (state == OUT);

    fir_tdm_rr_arb #(.NCH(NCH), .CHW(CH_W)) u_arb (
        .clk      (system1000),
        .rst_n    (system1000_rstn),
        .en       (arb_en),
        .req      (in_valid),
        .grant    (grant),
        .grant_ch (grant_ch)
    );

    assign sample = in_data[int'(grant_ch) * DW +: DW];

    // mac_cnt counts down TAPS-1..0, so its complement is the tap index k.
    assign tap_k    = ~mac_cnt;
    assign rd_idx   = wp[cur_ch] - PTR_W'(1) - tap_k;
    assign prod     = hist[cur_ch][rd_idx] * coef[tap_k];
    assign acc_next = acc + ACC_W'(prod);
    assign acc_ext  = 64'(acc_next);

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state    <= IDLE;
            cur_ch   <= '0;
            mac_cnt  <= '0;
            acc      <= '0;
            out_ch   <= '0;
            out_data <= '0;
            for (int c = 0; c < NCH; c++) begin
                wp[c] <= '0;
                for (int t = 0; t < TAPS; t++)
                    hist[c][t] <= '0;
            end
            for (int t = 0; t < TAPS; t++)
                coef[t] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we) begin
                        coef[coef_addr] <= coef_data;
                    end else if (|grant) begin
                        hist[grant_ch][wp[grant_ch]] <= sample;
                        wp[grant_ch] <= wp[grant_ch] + 1'b1;
                        cur_ch       <= grant_ch;
                        acc          <= '0;
                        mac_cnt      <= PTR_W'(TAPS - 1);
                        state        <= MAC;
                    end
                end
                MAC: begin
                    acc     <= acc_next;
                    mac_cnt <= mac_cnt - 1'b1;
                    if (mac_cnt == '0) begin
                        out_data <= DW'(round_narrow(acc_ext, DW, CW));
                        out_ch   <= cur_ch;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_tdm_sched.sv
// Directed scoreboard bench for fir_tdm_sched (NCH=4, TAPS=8, DW=CW=16).
module tb_fir_tdm_sched;

    localparam int NCH  = 4;
    localparam int TAPS = 8;
    localparam int DW   = 16;
    localparam int CW   = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH*DW-1:0] in_data = '0;
    logic [NCH-1:0]    in_ready;
    logic              coef_we = 1'b0;
    logic [2:0]        coef_addr = '0;
    logic [CW-1:0]     coef_data = '0;
    logic              coef_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int ch; logic [15:0] data; } exp_t;
    exp_t sb[$];

    logic signed [15:0] mh [NCH][TAPS];
    logic signed [15:0] mc [TAPS];
    int                 mwp [NCH];

    fir_tdm_sched #(.NCH(NCH), .TAPS(TAPS), .DW(DW), .CW(CW)) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .coef_ready      (coef_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_ch          (out_ch),
        .out_data        (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input int ch);
        longint acc = 0;
        longint r;
        for (int k = 0; k < TAPS; k++)
            acc += longint'(mh[ch][(mwp[ch] - 1 - k + 2 * TAPS) % TAPS]) * longint'(mc[k]);
        r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_TDM_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mwp[c] = 0;
            for (int t = 0; t < TAPS; t++) mh[c][t] = '0;
        end
        for (int t = 0; t < TAPS; t++) mc[t] = '0;
        sb.delete();
    endtask

    task automatic model_accept(input int ch, input logic [15:0] data);
        exp_t e;
        mh[ch][mwp[ch]] = data;
        mwp[ch] = (mwp[ch] + 1) % TAPS;
        e.ch = ch;
        e.data = model_out(ch);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        in_valid = '1;
        coef_we = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk("in_ready_in_reset", 32'(in_ready), 0);
        chk("out_valid_in_reset", 32'(out_valid), 0);
        in_valid = '0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic write_coef(input int addr, input logic [15:0] data);
        coef_we = 1'b1;
        coef_addr = 3'(addr);
        coef_data = data;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (coef_ready) break;
            @(negedge clk);
        end
        chk("coef_ready", 32'(coef_ready), 1);
        @(negedge clk);
        coef_we = 1'b0;
        mc[addr] = data;
    endtask

    task automatic send(input int ch, input logic [15:0] data, output int t0);
        t0 = cyc;
        in_valid[ch] = 1'b1;
        in_data[ch*DW +: DW] = data;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (in_ready[ch]) break;
            @(negedge clk);
        end
        chk("grant", 32'(in_ready), 32'(1 << ch));
        if (in_ready[ch]) begin
            t0 = cyc;
            model_accept(ch, data);
        end
        @(negedge clk);
        in_valid[ch] = 1'b0;
    endtask

    task automatic get_out(input int t0, input int hold, output logic [15:0] got);
        exp_t e;
        got = '0;
        for (int n = 0; n < 60; n++) begin
            #1;
            if (out_valid) break;
            @(negedge clk);
        end
        chk("out_valid_rise", 32'(out_valid), 1);
        chk("latency", 32'(cyc - t0), TAPS + 1);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_ch", 32'(out_ch), 32'(e.ch));
            chk("out_data", 32'(out_data), 32'(e.data));
            got = out_data;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(e.data));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1 chk("out_valid_drop", 32'(out_valid), 0);
    endtask

    initial begin
        int t0;
        logic [15:0] got;
        int gch [$];
        int gcy [$];
        int pend;
        int nout;

        // Reset values
        do_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_coef_ready", 32'(coef_ready), 1);

        // Single-tap passthrough
        write_coef(0, 16'h7FFF);
        send(0, 16'h1234, t0);
        get_out(t0, 0, got);
        chk("passthru", 32'(got), 32'h1234);

        // Moving average on channel 2
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'h1000);
        for (int s = 1; s <= 8; s++) begin
            send(2, 16'(s * 100), t0);
            get_out(t0, 0, got);
        end
        chk("avg8", 32'(got), 450);

        // Continuous requests on all channels
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'(16'h0800 * (k + 1)));
        for (int c = 0; c < NCH; c++) in_data[c*DW +: DW] = 16'(16'h0100 * (c + 1));
        out_ready = 1'b1;
        in_valid = '1;
        pend = -1;
        nout = 0;
        for (int n = 0; n < 80 && nout < 5; n++) begin
            #1;
            if (pend >= 0) begin
                in_data[pend*DW +: DW] = in_data[pend*DW +: DW] + 16'h0011;
                pend = -1;
                if (gch.size() == 5) in_valid = '0;
            end
            if (|in_ready) begin
                for (int c = 0; c < NCH; c++)
                    if (in_ready[c]) begin
                        gch.push_back(c);
                        gcy.push_back(cyc);
                        model_accept(c, in_data[c*DW +: DW]);
                        pend = c;
                    end
            end
            if (out_valid) begin
                exp_t e;
                chk("rr_sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rr_out_ch", 32'(out_ch), 32'(e.ch));
                    chk("rr_out_data", 32'(out_data), 32'(e.data));
                end
                nout++;
            end
            @(negedge clk);
        end
        in_valid = '0;
        out_ready = 1'b0;
        chk("rr_outputs", 32'(nout), 5);
        chk("rr_grants", 32'(gch.size()), 5);
        for (int g = 0; g < gch.size() && g < 5; g++) begin
            chk("rr_order", 32'(gch[g]), 32'(g % NCH));
            if (g > 0) chk("rr_spacing", 32'(gcy[g] - gcy[g-1]), TAPS + 2);
        end

        // Full-scale accumulation on channel 1
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'h7FFF);
        for (int s = 0; s < 8; s++) begin
            send(1, 16'h7FFF, t0);
            get_out(t0, 0, got);
        end
`ifdef FIR_TDM_SAT_EN
        chk("fullscale", 32'(got), 32'h7FFF);
`else
        chk("fullscale", 32'(got), 32'hFFF0);
`endif

        // Coefficient write beats a pending sample; stalled output holds
        @(negedge clk);
        coef_we = 1'b1;
        coef_addr = 3'd0;
        coef_data = 16'h2000;
        in_valid[3] = 1'b1;
        in_data[3*DW +: DW] = 16'h0400;
        #1;
        chk("prio_in_ready", 32'(in_ready), 0);
        chk("prio_coef_ready", 32'(coef_ready), 1);
        @(negedge clk);
        coef_we = 1'b0;
        mc[0] = 16'h2000;
        send(3, 16'h0400, t0);
        get_out(t0, 5, got);

        // Reset in the 4th MAC cycle
        send(0, 16'h0300, t0);
        while (cyc < t0 + 4) @(negedge clk);
        rstn = 1'b0;
        in_valid = '1;
        repeat (2) begin
            #1;
            chk("midrst_in_ready", 32'(in_ready), 0);
            chk("midrst_out_valid", 32'(out_valid), 0);
            @(negedge clk);
        end
        in_valid = '0;
        rstn = 1'b1;
        model_reset();
        repeat (15) begin
            #1 chk("post_rst_quiet", 32'(out_valid), 0);
            @(negedge clk);
        end
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'h4000);
        send(0, 16'h0200, t0);
        get_out(t0, 0, got);
        chk("cleared_hist", 32'(got), 32'h0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
